gf16_mul_array: RTL and testbench

//  Responder side of the digit-serial multiply/accumulate interface used by the GF(2^m) multiplier FSM.

---
 rtl/gf16_mul_array.sv | 129 ++++++++++++
 tb/tb_gf16_mul_array.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf16_mul_array.sv
// gf16_mul_array: LANES parallel GF(2^W) lanes computing r[k] = o[k]*t + add[k] mod POLY.
// The broadcast multiplier digit t is consumed DIGIT bits per cycle, MSB first (Horner),
// under a start/busy/done handshake. Vector bit 0 of every lane is the x^(W-1) coefficient.
module gf16_mul_array #(
  parameter int unsigned  LANES = 9,
  parameter int unsigned  W     = 16,
  parameter int unsigned  DIGIT = 4,
  parameter logic [W-1:0] POLY  = 16'h002D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [0:LANES*W-1] o_in,
  input  logic [0:W-1]       t_in,
  input  logic [0:LANES*W-1] add_in,
  output logic [0:LANES*W-1] r_dat,
  output logic               busy,
  output logic               done
);

  localparam int unsigned STEPS = W / DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Reject digit sizes that do not tile the lane width
  generate
    if (W % DIGIT != 0) begin : g_bad_digit
      $error("gf16_mul_array: W must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_d;
  logic [W-1:0]      o_q   [LANES];
  logic [W-1:0]      add_q [LANES];
  logic [W-1:0]      acc   [LANES];
  logic [W-1:0]      o_d   [LANES];
  logic [W-1:0]      add_d [LANES];
  logic [W-1:0]      acc_d [LANES];
  logic [W-1:0]      t_q, t_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [DIGIT-1:0]  dig;
  logic [0:LANES*W-1] r_d;
  logic              busy_d, done_d;

  // One Horner digit step: a*x^DIGIT + o*d, reduced one x^1 shift at a time
  function automatic logic [W-1:0] step_digit(input logic [W-1:0] a,
                                              input logic [W-1:0] o,
                                              input logic [DIGIT-1:0] d);
    logic [W-1:0] r;
    r = a;
    for (int i = int'(DIGIT) - 1; i >= 0; i--) begin
      r = {r[W-2:0], 1'b0} ^ (r[W-1] ? POLY : '0);
      if (d[i]) r = r ^ o;
    end
    return r;
  endfunction

  // Next-state, datapath and output logic
  always_comb begin
    state_d = state;
    busy_d  = busy;
    done_d  = 1'b0;
    r_d     = r_dat;
    t_d     = t_q;
    cnt_d   = cnt;
    o_d     = o_q;
    add_d   = add_q;
    acc_d   = acc;
    dig     = t_q[W-1 -: DIGIT];
    case (state)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < int'(LANES); k++) begin
            o_d[k]   = o_in[k*W +: W];
            add_d[k] = add_in[k*W +: W];
            acc_d[k] = '0;
          end
          t_d     = t_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < int'(LANES); k++) begin
          acc_d[k] = step_digit(acc[k], o_q[k], dig);
        end
        t_d   = t_q << DIGIT;
        cnt_d = CW'(cnt + 1'b1);
        if (cnt == CW'(STEPS - 1)) begin
          for (int k = 0; k < int'(LANES); k++) begin
            r_d[k*W +: W] = acc_d[k] ^ add_q[k];
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      r_dat <= '0;
      t_q   <= '0;
      cnt   <= '0;
      o_q   <= '{default: '0};
      add_q <= '{default: '0};
      acc   <= '{default: '0};
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
      r_dat <= r_d;
      t_q   <= t_d;
      cnt   <= cnt_d;
      o_q   <= o_d;
      add_q <= add_d;
      acc   <= acc_d;
    end
  end

endmodule

// File: tb/tb_gf16_mul_array.sv
// Directed and random checks of gf16_mul_array (9 lanes of GF(2^16), digit 4).
module tb_gf16_mul_array;

  localparam int LANES = 9;
  localparam int W     = 16;
  localparam int N     = LANES * W;

  logic           clk = 1'b0;
  logic           rst, start, busy, done;
  logic [0:N-1]   o_in, add_in, r_dat;
  logic [0:W-1]   t_in;

  int checks   = 0;
  int failures = 0;

  gf16_mul_array dut (
    .clk(clk), .rst(rst), .start(start), .o_in(o_in), .t_in(t_in),
    .add_in(add_in), .r_dat(r_dat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and pulse start across one edge
  task automatic launch(input logic [0:N-1] o, input logic [15:0] t, input logic [0:N-1] a);
    o_in = o; t_in = t; add_in = a; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [0:N-1] fill(input logic [15:0] v);
    logic [0:N-1] r;
    for (int k = 0; k < LANES; k++) r[k*W +: W] = v;
    return r;
  endfunction

  // Reference multiply: LSB-first shift-and-add over GF(2^16), poly 0x1002D
  function automatic logic [15:0] gmul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r, aa;
    r = '0; aa = a;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[15] ? ((aa << 1) ^ 16'h002D) : (aa << 1);
    end
    return r;
  endfunction

  task automatic test_reset();
    int seen;
    logic [0:N-1] zero;
    zero = '0;
    rst = 1'b1; start = 1'b0; o_in = '0; t_in = '0; add_in = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || r_dat !== zero) begin
      failures++;
      $display("FAIL reset_por busy=%b done=%b r=%h required 0 0 0", busy, done, r_dat);
    end
    // give r_dat a non-zero value, then abort a run mid-way
    launch(fill(16'h0001), 16'h1234, fill(16'h0000));
    wait_done(seen);
    tick();
    launch(fill(16'h0001), 16'h5555, fill(16'h7777));
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || r_dat !== zero) begin
      failures++;
      $display("FAIL reset_midrun busy=%b done=%b r=%h required 0 0 0", busy, done, r_dat);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_no_done got done pulse after abort, required none");
    end
  endtask

  task automatic test_identity();
    int cyc;
    launch(fill(16'h0001), 16'hABCD, fill(16'h1111));
    o_in = '1; t_in = '0; add_in = '0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL identity_busy got %b required 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin
      failures++;
      $display("FAIL identity_latency got %0d required 4", cyc);
    end
    checks++;
    if (r_dat !== fill(16'hBADC) || busy !== 1'b0) begin
      failures++;
      $display("FAIL identity_result r=%h busy=%b required %h busy=0", r_dat, busy, fill(16'hBADC));
    end
    tick();
    checks++;
    if (done !== 1'b0 || r_dat !== fill(16'hBADC)) begin
      failures++;
      $display("FAIL identity_done_pulse done=%b r=%h required 0 and held result", done, r_dat);
    end
  endtask

  task automatic test_reduction();
    int cyc;
    logic [0:N-1] o, exp;
    o = '0; o[0 +: W] = 16'h8000;
    exp = '0; exp[0 +: W] = 16'h002D;
    launch(o, 16'h0002, '0);
    wait_done(cyc);
    checks++;
    if (r_dat !== exp) begin
      failures++;
      $display("FAIL reduction_x16 got %h required %h", r_dat, exp);
    end
    tick();
    o = '0; o[W +: W] = 16'h8000;
    exp = '0; exp[W +: W] = 16'h005A;
    launch(o, 16'h0004, '0);
    wait_done(cyc);
    checks++;
    if (r_dat !== exp) begin
      failures++;
      $display("FAIL reduction_x17 got %h required %h", r_dat, exp);
    end
    tick();
  endtask

  task automatic test_lane_isolation();
    int cyc;
    logic [0:N-1] o, a, exp;
    logic [15:0] v;
    for (int k = 0; k < LANES; k++) begin
      o = '0;
      for (int j = 0; j < LANES; j++) a[j*W +: W] = 16'h0F00 + 16'(j);
      v = 16'(k + 1);
      o[k*W +: W] = v;
      exp = a;
      exp[k*W +: W] = ((v << 1) ^ v) ^ a[k*W +: W];
      launch(o, 16'h0003, a);
      wait_done(cyc);
      checks++;
      if (r_dat !== exp) begin
        failures++;
        $display("FAIL lane_iso_%0d got %h required %h", k, r_dat, exp);
      end
      tick();
    end
  endtask

  task automatic test_handshake();
    int cyc;
    logic [0:N-1] exp2;
    launch(fill(16'h0001), 16'h0F0F, fill(16'h0000));
    tick();
    // spurious start with different operands while busy
    o_in = fill(16'hFFFF); t_in = 16'hFFFF; add_in = fill(16'h1234); start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL handshake_busy got %b required 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (r_dat !== fill(16'h0F0F)) begin
      failures++;
      $display("FAIL handshake_ignore got %h required %h", r_dat, fill(16'h0F0F));
    end
    // start held in the done cycle is accepted
    o_in = fill(16'h0002); t_in = 16'h0003; add_in = fill(16'h0001); start = 1'b1;
    exp2 = fill(16'h0007);
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL handshake_b2b_accept done=%b busy=%b required 0 1", done, busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc + 1 !== 5 || r_dat !== exp2) begin
      failures++;
      $display("FAIL handshake_b2b cycles=%0d r=%h required 5 %h", cyc + 1, r_dat, exp2);
    end
  endtask

  task automatic test_random();
    int cyc, gap;
    logic [0:N-1] o, a, exp;
    logic [15:0] t, ov;
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      t = 16'($urandom);
      for (int k = 0; k < LANES; k++) begin
        ov = 16'($urandom);
        if ($urandom_range(0, 15) == 0) ov = '0;
        o[k*W +: W] = ov;
        a[k*W +: W] = 16'($urandom);
        exp[k*W +: W] = gmul(ov, t) ^ a[k*W +: W];
      end
      if ($urandom_range(0, 31) == 0) begin
        t = '0;
        exp = a;
      end
      launch(o, t, a);
      o_in = ~o; t_in = ~t; add_in = ~a;
      wait_done(cyc);
      checks++;
      if (cyc !== 4 || r_dat !== exp) begin
        failures++;
        $display("FAIL random_%0d cycles=%0d r=%h required 4 %h", i, cyc, r_dat, exp);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reduction();
    test_lane_isolation();
    test_handshake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
